// File: rtl/wb_stage_unit.sv
// Write-back stage: MEM/WB pipeline register, load/ALU result select, and a
// stall/timeout FSM that waits on variable-latency load data.
module wb_stage_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int PC_REG  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [3:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              flush,
  input  logic              rdata_valid,
  input  logic [DATA_W-1:0] rdata,
  output logic              wb_stall,
  output logic [3:0]        Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              writeBackEn,
  output logic              pc_wr_blocked,
  output logic              mem_timeout,
  output logic [31:0]       retire_count
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]      PC_IDX   = 4'(PC_REG);

  typedef enum logic {IDLE, WAIT_MEM} state_t;
  typedef struct packed {
    logic       wb_en;
    logic [3:0] dest;
  } wb_req_t;

  state_t            state_q, state_d;
  wb_req_t           req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        dest_q;
  logic [DATA_W-1:0] result_q;
  logic              wbe_q, pc_blk_q, tmo_q;
  logic [31:0]       retire_q;

  logic              accept_now, start_wait, load_done, timeout_hit, retire;
  logic              wr_en, pc_hit;
  logic [3:0]        wr_dest;
  logic [DATA_W-1:0] wr_data;

  // Flush kills whatever is presented or pending, including same-cycle data.
  always_comb begin
    accept_now  = (state_q == IDLE) && mem_valid && !flush && (!mem_r_en || rdata_valid);
    start_wait  = (state_q == IDLE) && mem_valid && !flush && mem_r_en && !rdata_valid;
    load_done   = (state_q == WAIT_MEM) && !flush && rdata_valid;
    timeout_hit = (state_q == WAIT_MEM) && !flush && !rdata_valid && (cnt_q == CNT_LAST);
    retire      = accept_now || load_done;
    wr_en       = accept_now ? mem_wb_en : req_q.wb_en;
    wr_dest     = accept_now ? mem_dest  : req_q.dest;
    wr_data     = (accept_now && !mem_r_en) ? mem_alu_result : rdata;
    pc_hit      = wr_en && (wr_dest == PC_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_wait) state_d = WAIT_MEM;
      WAIT_MEM: if (flush || rdata_valid || timeout_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_stall = (state_q == WAIT_MEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      result_q <= '0;
      wbe_q    <= 1'b0;
      pc_blk_q <= 1'b0;
      tmo_q    <= 1'b0;
      retire_q <= '0;
    end else begin
      wbe_q <= retire && wr_en && !pc_hit;
      if (start_wait) begin
        req_q <= '{wb_en: mem_wb_en, dest: mem_dest};
        cnt_q <= '0;
      end else if ((state_q == WAIT_MEM) && !flush && !rdata_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (retire) begin
        dest_q   <= wr_dest;
        result_q <= wr_data;
        retire_q <= retire_q + 32'd1;
      end
      if (retire && pc_hit) pc_blk_q <= 1'b1;
      if (timeout_hit)      tmo_q    <= 1'b1;
    end
  end

  assign Dest_wb       = dest_q;
  assign Result_WB     = result_q;
  assign writeBackEn   = wbe_q;
  assign pc_wr_blocked = pc_blk_q;
  assign mem_timeout   = tmo_q;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_wb_stage_unit.sv
// Directed bench for wb_stage_unit: ALU/load write-back, stall/timeout,
// PC write blocking, flush and reset behaviour.
module tb_wb_stage_unit;
  logic        clk = 1'b0;
  logic        rst, mem_valid, mem_wb_en, mem_r_en, flush, rdata_valid;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_result, rdata;
  logic        wb_stall, writeBackEn, pc_wr_blocked, mem_timeout;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB, retire_count;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_stage_unit #(.DATA_W(32), .TIMEOUT(16), .PC_REG(15)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
    .mem_r_en(mem_r_en), .mem_dest(mem_dest), .mem_alu_result(mem_alu_result),
    .flush(flush), .rdata_valid(rdata_valid), .rdata(rdata),
    .wb_stall(wb_stall), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .writeBackEn(writeBackEn), .pc_wr_blocked(pc_wr_blocked),
    .mem_timeout(mem_timeout), .retire_count(retire_count));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    rst = 0; mem_valid = 0; mem_wb_en = 0; mem_r_en = 0; mem_dest = 0;
    mem_alu_result = 0; flush = 0; rdata_valid = 0; rdata = 0;
  endtask

  task automatic present(input logic we, input logic re, input logic [3:0] d, input logic [31:0] a);
    mem_valid = 1; mem_wb_en = we; mem_r_en = re; mem_dest = d; mem_alu_result = a;
  endtask

  task automatic test_reset();
    clr(); rst = 1; present(1, 0, 4'd3, 32'hFFFF_FFFF); rdata_valid = 1;
    tick(); tick(); clr();
    n_cmp++; if (wb_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", wb_stall); end
    n_cmp++; if (writeBackEn !== 1'b0) begin n_err++; $display("FAIL rst_wbe got %b exp 0", writeBackEn); end
    n_cmp++; if (Dest_wb !== 4'd0 || Result_WB !== 32'd0) begin n_err++; $display("FAIL rst_wport got %h/%h exp 0/0", Dest_wb, Result_WB); end
    n_cmp++; if (pc_wr_blocked !== 1'b0 || mem_timeout !== 1'b0 || retire_count !== 32'd0) begin n_err++; $display("FAIL rst_flags got %b/%b/%0d exp 0/0/0", pc_wr_blocked, mem_timeout, retire_count); end
  endtask

  task automatic test_alu();
    present(1, 0, 4'd3, 32'h0000_00AA); tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd3 || Result_WB !== 32'hAA) begin n_err++; $display("FAIL alu_write got %b/%0d/%h exp 1/3/aa", writeBackEn, Dest_wb, Result_WB); end
    tick();
    n_cmp++; if (writeBackEn !== 1'b0 || Result_WB !== 32'hAA) begin n_err++; $display("FAIL alu_pulse got %b/%h exp 0/aa", writeBackEn, Result_WB); end
    n_cmp++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL alu_retire got %0d exp 1", retire_count); end
  endtask

  task automatic test_load();
    int st = 0;
    present(1, 1, 4'd5, 32'h100); tick();
    for (int i = 0; i < 4; i++) begin
      if (wb_stall === 1'b1) st++;
      if (i == 3) begin rdata_valid = 1; rdata = 32'hDEAD_BEEF; end
      tick();
    end
    clr();
    n_cmp++; if (st != 4) begin n_err++; $display("FAIL load_stall got %0d cycles exp 4", st); end
    n_cmp++; if (wb_stall !== 1'b0 || writeBackEn !== 1'b1 || Dest_wb !== 4'd5 || Result_WB !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_write got %b/%b/%0d/%h exp 0/1/5/deadbeef", wb_stall, writeBackEn, Dest_wb, Result_WB); end
    n_cmp++; if (retire_count !== 32'd2) begin n_err++; $display("FAIL load_retire got %0d exp 2", retire_count); end
  endtask

  // Data arriving on the last allowed wait cycle must win over the timeout.
  task automatic test_load_late();
    present(1, 1, 4'd7, 32'h0); tick(); clr();
    for (int i = 0; i < 15; i++) tick();
    rdata_valid = 1; rdata = 32'h55; tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd7 || Result_WB !== 32'h55) begin n_err++; $display("FAIL late_write got %b/%0d/%h exp 1/7/55", writeBackEn, Dest_wb, Result_WB); end
    n_cmp++; if (mem_timeout !== 1'b0 || retire_count !== 32'd3) begin n_err++; $display("FAIL late_flags got %b/%0d exp 0/3", mem_timeout, retire_count); end
  endtask

  task automatic test_timeout();
    int st = 0;
    present(1, 1, 4'd6, 32'h0); tick(); clr();
    while (wb_stall === 1'b1 && st < 40) begin st++; tick(); end
    n_cmp++; if (st != 16) begin n_err++; $display("FAIL tmo_stall got %0d cycles exp 16", st); end
    n_cmp++; if (mem_timeout !== 1'b1 || writeBackEn !== 1'b0 || retire_count !== 32'd3) begin n_err++; $display("FAIL tmo_flags got %b/%b/%0d exp 1/0/3", mem_timeout, writeBackEn, retire_count); end
  endtask

  task automatic test_pc_block();
    present(1, 0, 4'd15, 32'h1234); tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b0 || pc_wr_blocked !== 1'b1 || retire_count !== 32'd4) begin n_err++; $display("FAIL pc_block got %b/%b/%0d exp 0/1/4", writeBackEn, pc_wr_blocked, retire_count); end
    present(0, 0, 4'd2, 32'h77); tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd2 || Result_WB !== 32'h77 || retire_count !== 32'd5) begin n_err++; $display("FAIL no_wben got %b/%0d/%h/%0d exp 0/2/77/5", writeBackEn, Dest_wb, Result_WB, retire_count); end
    rdata_valid = 1; rdata = 32'h99; tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b0 || Result_WB !== 32'h77 || retire_count !== 32'd5) begin n_err++; $display("FAIL idle_rdata got %b/%h/%0d exp 0/77/5", writeBackEn, Result_WB, retire_count); end
  endtask

  task automatic test_flush();
    present(1, 1, 4'd8, 32'h0); tick(); clr();
    tick(); flush = 1; tick(); clr();
    n_cmp++; if (wb_stall !== 1'b0 || writeBackEn !== 1'b0) begin n_err++; $display("FAIL flush_wait got %b/%b exp 0/0", wb_stall, writeBackEn); end
    rdata_valid = 1; rdata = 32'h1; tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b0 || retire_count !== 32'd5) begin n_err++; $display("FAIL flush_late_data got %b/%0d exp 0/5", writeBackEn, retire_count); end
    present(1, 0, 4'd9, 32'h9); flush = 1; tick(); clr();
    n_cmp++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd2 || retire_count !== 32'd5) begin n_err++; $display("FAIL flush_idle got %b/%0d/%0d exp 0/2/5", writeBackEn, Dest_wb, retire_count); end
    present(1, 0, 4'd10, 32'hA); tick(); clr(); flush = 1; #1;
    n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd10 || retire_count !== 32'd6) begin n_err++; $display("FAIL flush_keep_wbe got %b/%0d/%0d exp 1/10/6", writeBackEn, Dest_wb, retire_count); end
    tick(); clr();
  endtask

  task automatic test_reset_mid_wait();
    present(1, 1, 4'd11, 32'h0); tick(); clr(); tick();
    n_cmp++; if (wb_stall !== 1'b1) begin n_err++; $display("FAIL rmid_pre got %b exp 1", wb_stall); end
    rst = 1; tick(); clr();
    n_cmp++; if (wb_stall !== 1'b0 || writeBackEn !== 1'b0 || Dest_wb !== 4'd0 || Result_WB !== 32'd0) begin n_err++; $display("FAIL rmid_port got %b/%b/%0d/%h exp 0/0/0/0", wb_stall, writeBackEn, Dest_wb, Result_WB); end
    n_cmp++; if (pc_wr_blocked !== 1'b0 || mem_timeout !== 1'b0 || retire_count !== 32'd0) begin n_err++; $display("FAIL rmid_flags got %b/%b/%0d exp 0/0/0", pc_wr_blocked, mem_timeout, retire_count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      present(1, 0, 4'(i), 32'h100 + 32'(i)); tick();
      n_cmp++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'(i) || Result_WB !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b_%0d got %b/%0d/%h exp 1/%0d/%h", i, writeBackEn, Dest_wb, Result_WB, i, 32'h100 + 32'(i)); end
    end
    clr(); tick();
    n_cmp++; if (writeBackEn !== 1'b0 || retire_count !== 32'd4) begin n_err++; $display("FAIL b2b_end got %b/%0d exp 0/4", writeBackEn, retire_count); end
  endtask

  initial begin
    clr();
    test_reset();
    test_alu();
    test_load();
    test_load_late();
    test_timeout();
    test_pc_block();
    test_flush();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage_unit.md
Name: wb_stage_unit

Overview:
- Write-back stage of the ARM pipeline and the producer side of the register-file write port: drives Dest_wb, Result_WB and writeBackEn.
- Registers MEM-stage results (MEM/WB pipeline register) and selects ALU result or load data.
- Waits on a variable-latency memory read with a stall/timeout state machine.
- Sits between the MEM stage/data memory and the register file; the register file samples the write port on the negative edge.

Parameters:
- DATA_W, 32, width of result/data paths
- TIMEOUT, 16, max cycles waiting for load data before abort (>=1)
- PC_REG, 15, register index reserved as PC; writes to it are blocked

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_wb_en  in  1  instruction writes a register
- mem_r_en  in  1  instruction is a load (result from rdata)
- mem_dest  in  4  destination register index
- mem_alu_result  in  DATA_W  ALU result / address
- flush  in  1  discard captured/pending instruction
- rdata_valid  in  1  load data valid strobe from memory
- rdata  in  DATA_W  load data
- wb_stall  out  1  freeze request to upstream stages
- Dest_wb  out  4  register-file write index
- Result_WB  out  DATA_W  register-file write data
- writeBackEn  out  1  register-file write enable (one-cycle pulse)
- pc_wr_blocked  out  1  sticky: a write to PC_REG was suppressed
- mem_timeout  out  1  sticky: a load was aborted by timeout
- retire_count  out  32  retired instructions, wraps at 2^32

Behaviour:
- Reset (sync, dominates all inputs): state=IDLE; wb_stall=0; Dest_wb=0; Result_WB=0; writeBackEn=0; pc_wr_blocked=0; mem_timeout=0; retire_count=0; wait counter=0.
- States: IDLE, WAIT_MEM. wb_stall = (state==WAIT_MEM), combinational from state.
- IDLE, mem_valid=1, mem_r_en=0:
  - Next cycle: writeBackEn = mem_wb_en && mem_dest!=PC_REG; Dest_wb=mem_dest; Result_WB=mem_alu_result.
  - Latency 1 cycle. retire_count+1.
- IDLE, mem_valid=1, mem_r_en=1, rdata_valid=1 same cycle: as above with Result_WB=rdata; latency 1.
- IDLE, mem_valid=1, mem_r_en=1, rdata_valid=0: capture mem_dest and mem_wb_en; go to WAIT_MEM; counter=0.
- WAIT_MEM:
  - mem_valid ignored; upstream holds its instruction while wb_stall=1.
  - rdata_valid=1: next cycle write with Result_WB=rdata and the captured dest/en (PC_REG rule applies); retire_count+1; state IDLE.
  - Otherwise counter+1. When counter reaches TIMEOUT-1 without data: mem_timeout<=1; no write; no retire; state IDLE.
- PC_REG rule: writeBackEn stays 0 and pc_wr_blocked<=1 when mem_wb_en=1 and dest==PC_REG. The instruction still counts as retired.
- mem_wb_en=0 instructions retire with writeBackEn=0. Dest_wb/Result_WB still update.
- writeBackEn is high for exactly one cycle per write. Dest_wb/Result_WB hold their last value otherwise.
- flush:
  - IDLE: the same-cycle mem_valid instruction is dropped (no write, no retire).
  - WAIT_MEM: load aborted, state IDLE, no write. A same-cycle rdata_valid is discarded.
  - flush does not cancel a writeBackEn already registered for the current cycle.
- rdata_valid in IDLE with no load presented: ignored.
- Timeout and rdata_valid on the same cycle: data wins (write happens, no timeout flag).
- Sticky flags clear only on rst.

Test Plan:
- rst; IDLE mem_valid, wb_en=1, r_en=0, dest=3, alu=0x0000_00AA -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0xAA; following cycle writeBackEn=0; retire_count=1.
- Load dest=5, rdata_valid after 4 cycles with 0xDEAD_BEEF -> wb_stall=1 for 4 cycles, then write Dest_wb=5, Result_WB=0xDEADBEEF, wb_stall=0.
- Load with no rdata_valid, TIMEOUT=16 -> wb_stall=1 for 16 cycles, then mem_timeout=1, no writeBackEn, retire_count unchanged.
- ALU write dest=15, value 0x1234 -> writeBackEn stays 0, pc_wr_blocked=1, retire_count+1.
- Flush in cycle 2 of WAIT_MEM, then rdata_valid -> no write, state IDLE, wb_stall=0. Separately, rst asserted mid-WAIT_MEM -> all outputs at reset values next cycle.
- Back-to-back ALU instructions dest=1..4 on 4 consecutive cycles -> 4 consecutive writeBackEn pulses, each with the matching Dest_wb/Result_WB; retire_count=4.
